mdio_responder: RTL

MDIO (IEEE 802.3 Clause 22) management responder: the PHY-side counterpart to the Ethernet PHY configuration initiator. It decodes MDC/MDIO frames, holds a 32 × 16 register file plus a small Clause 45 MMD store reached indirectly through registers 13/14, and answers reads on MDIO. It sits in PHY-emulation builds and loopback benches, so the PHY configuration path can run without a physical PHY. Register 31 reports externally supplied speed/duplex.

---
 rtl/mdio_responder.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mdio_responder.sv
// MDIO Clause 22 management responder: decodes MDC/MDIO frames against a 32 x 16 register file
// and a small Clause 45 MMD store reached indirectly through registers 13/14.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter logic [4:0]  MMD_DEV      = 5'd2,
    parameter int unsigned PREAMBLE_MIN = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic [1:0]  speed_in,
    input  logic        duplex_in,
    output logic        wr_strobe,
    output logic        wr_mmd,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);
    localparam int               CNT_W    = $clog2(PREAMBLE_MIN + 1);
    localparam logic [CNT_W-1:0] PRE_FULL = CNT_W'(PREAMBLE_MIN);

    typedef enum logic [2:0] {ST_PRE, ST_HDR, ST_SKIP, ST_TA, ST_DATA} state_t;

    genvar gi;

    logic [1:0]       mdc_sync_reg, mdio_sync_reg;
    logic             mdc_dly_reg;
    logic             mdc_rise, mdio_bit;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] pre_cnt_reg, pre_cnt_next;
    logic [4:0]       bit_cnt_reg, bit_cnt_next;
    logic [12:0]      hdr_reg, hdr_next;
    logic [15:0]      data_sh_reg, data_sh_next;
    logic             is_read_reg, is_read_next;
    logic [4:0]       regad_reg, regad_next;
    logic             mdio_out_reg, mdio_out_next;
    logic             mdio_oe_reg, mdio_oe_next;
    logic             frame_err_reg, frame_err_next;
    logic             wr_strobe_reg, wr_mmd_reg;
    logic [4:0]       wr_addr_reg;
    logic [15:0]      wr_data_reg;
    logic [15:0]      mmd_ptr_reg;

    logic [13:0]      hdr_full;
    logic [1:0]       hdr_st, hdr_op;
    logic [4:0]       hdr_phy, hdr_regad;
    logic [15:0]      rd_mux;
    logic             wr_commit;
    logic [15:0]      wr_value;
    logic [1:0]       mmd_func;
    logic             mmd_ok;
    logic             dir_we, ptr_we, mmd_we;

    logic [15:0]      regs [32];
    logic [15:0]      mmd  [16];

    // Two-flop synchronizers; decoding runs only on detected MDC rising edges.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mdc_sync_reg  <= 2'b00;
            mdio_sync_reg <= 2'b00;
            mdc_dly_reg   <= 1'b0;
        end else begin
            mdc_sync_reg  <= {mdc_sync_reg[0], mdc};
            mdio_sync_reg <= {mdio_sync_reg[0], mdio_in};
            mdc_dly_reg   <= mdc_sync_reg[1];
        end
    end

    assign mdc_rise = mdc_sync_reg[1] & ~mdc_dly_reg;
    assign mdio_bit = mdio_sync_reg[1];

    // The preamble-terminating 0 sits implicitly in hdr_full[13] (hdr_reg starts cleared).
    assign hdr_full  = {hdr_reg, mdio_bit};
    assign hdr_st    = hdr_full[13:12];
    assign hdr_op    = hdr_full[11:10];
    assign hdr_phy   = hdr_full[9:5];
    assign hdr_regad = hdr_full[4:0];

    assign mmd_func = regs[13][15:14];
    assign mmd_ok   = (regs[13][4:0] == MMD_DEV) && (mmd_ptr_reg[15:4] == 12'h000);

    always_comb begin
        rd_mux = regs[hdr_regad];
        if (hdr_regad == 5'd31) begin
            rd_mux = {9'b0, speed_in, 1'b0, duplex_in, 3'b0};
        end else if (hdr_regad == 5'd14) begin
            if (mmd_func == 2'b00) begin
                rd_mux = mmd_ptr_reg;
            end else if (mmd_ok) begin
                rd_mux = mmd[mmd_ptr_reg[3:0]];
            end else begin
                rd_mux = 16'h0000;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        pre_cnt_next   = pre_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        hdr_next       = hdr_reg;
        data_sh_next   = data_sh_reg;
        is_read_next   = is_read_reg;
        regad_next     = regad_reg;
        mdio_out_next  = mdio_out_reg;
        mdio_oe_next   = mdio_oe_reg;
        frame_err_next = 1'b0;
        wr_commit      = 1'b0;
        wr_value       = {data_sh_reg[14:0], mdio_bit};
        if (mdc_rise) begin
            case (state_reg)
                ST_PRE: begin
                    if (mdio_bit) begin
                        if (pre_cnt_reg != PRE_FULL) begin
                            pre_cnt_next = pre_cnt_reg + 1'b1;
                        end
                    end else if (pre_cnt_reg == PRE_FULL) begin
                        state_next   = ST_HDR;
                        pre_cnt_next = '0;
                        bit_cnt_next = 5'd0;
                        hdr_next     = 13'd0;
                    end else begin
                        pre_cnt_next = '0;
                    end
                end
                ST_HDR: begin
                    hdr_next     = {hdr_reg[11:0], mdio_bit};
                    bit_cnt_next = bit_cnt_reg + 5'd1;
                    if (bit_cnt_reg == 5'd12) begin
                        bit_cnt_next = 5'd0;
                        regad_next   = hdr_regad;
                        is_read_next = (hdr_op == 2'b10);
                        if (hdr_st != 2'b01 || (hdr_op != 2'b10 && hdr_op != 2'b01)) begin
                            frame_err_next = 1'b1;
                            state_next     = ST_SKIP;
                        end else if (hdr_phy != PHY_ADDR) begin
                            state_next = ST_SKIP;
                        end else begin
                            state_next   = ST_TA;
                            data_sh_next = rd_mux;
                        end
                    end
                end
                ST_SKIP: begin
                    bit_cnt_next = bit_cnt_reg + 5'd1;
                    if (bit_cnt_reg == 5'd17) begin
                        state_next   = ST_PRE;
                        pre_cnt_next = '0;
                        bit_cnt_next = 5'd0;
                    end
                end
                ST_TA: begin
                    bit_cnt_next = bit_cnt_reg + 5'd1;
                    if (bit_cnt_reg == 5'd0) begin
                        if (is_read_reg) begin
                            mdio_oe_next  = 1'b1;
                            mdio_out_next = 1'b0;
                        end
                    end else begin
                        bit_cnt_next = 5'd0;
                        state_next   = ST_DATA;
                        if (is_read_reg) begin
                            mdio_out_next = data_sh_reg[15];
                            data_sh_next  = {data_sh_reg[14:0], 1'b0};
                        end
                    end
                end
                ST_DATA: begin
                    bit_cnt_next = bit_cnt_reg + 5'd1;
                    data_sh_next = wr_value;
                    if (is_read_reg) begin
                        mdio_out_next = data_sh_reg[15];
                    end
                    if (bit_cnt_reg == 5'd15) begin
                        state_next    = ST_PRE;
                        pre_cnt_next  = '0;
                        bit_cnt_next  = 5'd0;
                        mdio_oe_next  = 1'b0;
                        mdio_out_next = 1'b0;
                        wr_commit     = ~is_read_reg;
                    end
                end
                default: state_next = ST_PRE;
            endcase
        end
    end

    // Reg 31 is read-only; reg 14 either loads the pointer or forwards to the MMD store.
    assign dir_we = wr_commit && (regad_reg != 5'd14) && (regad_reg != 5'd31);
    assign ptr_we = wr_commit && (regad_reg == 5'd14) && (mmd_func == 2'b00);
    assign mmd_we = wr_commit && (regad_reg == 5'd14) && (mmd_func != 2'b00) && mmd_ok;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= ST_PRE;
            pre_cnt_reg   <= '0;
            bit_cnt_reg   <= 5'd0;
            hdr_reg       <= 13'd0;
            data_sh_reg   <= 16'h0000;
            is_read_reg   <= 1'b0;
            regad_reg     <= 5'd0;
            mdio_out_reg  <= 1'b0;
            mdio_oe_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_mmd_reg    <= 1'b0;
            wr_addr_reg   <= 5'd0;
            wr_data_reg   <= 16'h0000;
            mmd_ptr_reg   <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            pre_cnt_reg   <= pre_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            hdr_reg       <= hdr_next;
            data_sh_reg   <= data_sh_next;
            is_read_reg   <= is_read_next;
            regad_reg     <= regad_next;
            mdio_out_reg  <= mdio_out_next;
            mdio_oe_reg   <= mdio_oe_next;
            frame_err_reg <= frame_err_next;
            wr_strobe_reg <= dir_we | ptr_we | mmd_we;
            if (dir_we || ptr_we || mmd_we) begin
                wr_mmd_reg  <= mmd_we;
                wr_addr_reg <= mmd_we ? mmd_ptr_reg[4:0] : regad_reg;
                wr_data_reg <= wr_value;
            end
            if (ptr_we) begin
                mmd_ptr_reg <= wr_value;
            end
        end
    end

    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 14 || gi == 31) begin : g_virtual
                assign regs[gi] = 16'h0000;
            end else begin : g_store
                localparam logic [15:0] RST_VAL = (gi == 0) ? 16'h1140 :
                                                  (gi == 9) ? 16'h0200 : 16'h0000;
                // Reg 0 bit 15 is a self-clearing reset request, so it never sticks.
                localparam logic [15:0] WR_MASK = (gi == 0) ? 16'h7FFF : 16'hFFFF;
                logic [15:0] q_reg;
                always_ff @(posedge clock) begin
                    if (!reset_n) begin
                        q_reg <= RST_VAL;
                    end else if (dir_we && regad_reg == 5'(gi)) begin
                        q_reg <= wr_value & WR_MASK;
                    end
                end
                assign regs[gi] = q_reg;
            end
        end

        for (gi = 0; gi < 16; gi++) begin : g_mmd
            localparam logic [15:0] MMD_RST = (gi == 4)             ? 16'h0070 :
                                              (gi == 5 || gi == 6)  ? 16'h7777 :
                                              (gi == 8)             ? 16'h03EF : 16'h0000;
            logic [15:0] q_reg;
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    q_reg <= MMD_RST;
                end else if (mmd_we && mmd_ptr_reg[3:0] == 4'(gi)) begin
                    q_reg <= wr_value;
                end
            end
            assign mmd[gi] = q_reg;
        end
    endgenerate

    assign mdio_out  = mdio_out_reg;
    assign mdio_oe   = mdio_oe_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_mmd    = wr_mmd_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign frame_err = frame_err_reg;

endmodule
